// File: rtl/pcs_descr_pkg.sv
// Shared constants and types for the 64b/66b receive descrambler (g(x) = x^58 + x^39 + 1).
// The optional sync-header error counter is enabled by PCS_DESCR_SH_ERR_CNT_EN in the top.
package pcs_descr_pkg;

    localparam int DESCR_DATA_W  = 64;
    localparam int DESCR_STATE_W = 58;
    localparam int DESCR_TAP     = 39;
    localparam int SH_W          = 2;

    localparam logic [SH_W-1:0] SH_DATA = 2'b01;
    localparam logic [SH_W-1:0] SH_CTRL = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } descr_state_t;

    function automatic logic sh_is_valid(input logic [SH_W-1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/Parallel_LFSR.sv
// Combinational 64-bit parallel step of the x^58 + x^39 + 1 (de)scrambler.
// FEED_FORWARD=1 descrambles (self-synchronising); FEED_FORWARD=0 scrambles.
module Parallel_LFSR
    import pcs_descr_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter bit FEED_FORWARD = 1
) (
    input  logic [DESCR_STATE_W-1:0] state_in,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic [DESCR_STATE_W-1:0] state_out
);

    localparam int SEQ_W = DESCR_STATE_W + DATA_WIDTH;
    localparam int NEAR  = DESCR_STATE_W - DESCR_TAP;

    // seq[k] holds line bit k-58, so history occupies seq[57:0] and the block sits above it.
    logic [SEQ_W-1:0] seq;

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        seq      = {data_in, state_in};
        data_out = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (FEED_FORWARD) begin
                data_out[i] = seq[i+DESCR_STATE_W] ^ seq[i+NEAR] ^ seq[i];
            end else begin
                data_out[i]            = data_in[i] ^ seq[i+NEAR] ^ seq[i];
                seq[i+DESCR_STATE_W]   = data_out[i];
            end
        end
        state_out = seq[SEQ_W-1:DATA_WIDTH];
    end

endmodule

// File: rtl/pcs_descrambler_ctrl.sv
// Priming FSM, history register and registered valid/ready stage around the PCS descrambler.
// Define PCS_DESCR_SH_ERR_CNT_EN to add the saturating invalid-sync-header counter.
module pcs_descrambler_ctrl
    import pcs_descr_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  lock_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [HDR_WIDTH-1:0]  in_hdr,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [HDR_WIDTH-1:0]  out_hdr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  primed
`ifdef PCS_DESCR_SH_ERR_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  sh_err_cnt,
    input  logic                  sh_err_clr
`endif
);

    generate
        if (DATA_WIDTH != DESCR_DATA_W || HDR_WIDTH != SH_W || CNT_WIDTH < 1) begin : g_bad_cfg
            $error("pcs_descrambler_ctrl: only DATA_WIDTH=64, HDR_WIDTH=2, CNT_WIDTH>=1 supported");
        end
    endgenerate

    descr_state_t            state_q, state_d;
    logic [DESCR_STATE_W-1:0] hist_q, hist_d;
    logic                    out_valid_q, out_valid_d;
    logic [HDR_WIDTH-1:0]    out_hdr_q, out_hdr_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;

    logic [DATA_WIDTH-1:0]    descr_data;
    logic [DESCR_STATE_W-1:0] descr_state;
    logic                     accept;

    Parallel_LFSR #(
        .DATA_WIDTH  (DATA_WIDTH),
        .FEED_FORWARD(1'b1)
    ) u_lfsr (
        .state_in (hist_q),
        .data_in  (in_data),
        .data_out (descr_data),
        .state_out(descr_state)
    );

    assign in_ready = lock_in && (state_q != IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        out_valid_d = out_valid_q;
        out_hdr_d   = out_hdr_q;
        out_data_d  = out_data_q;

        case (state_q)
            IDLE:    state_d = PRIME;
            PRIME:   if (accept) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            hist_d = descr_state;
        end

        // Losing lock drops any pending block; history is kept and re-primed on relock.
        if (!lock_in) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else if (accept && state_q == RUN) begin
            out_valid_d = 1'b1;
            out_hdr_d   = in_hdr;
            out_data_d  = descr_data;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hist_q      <= '0;
            out_valid_q <= 1'b0;
            out_hdr_q   <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            out_valid_q <= out_valid_d;
            out_hdr_q   <= out_hdr_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_hdr   = out_hdr_q;
    assign out_data  = out_data_q;
    assign primed    = (state_q == RUN);

`ifdef PCS_DESCR_SH_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (sh_err_clr) begin
            cnt_d = '0;
        end else if (accept && !sh_is_valid(in_hdr) && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sh_err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pcs_descrambler_ctrl.sv
// Self-checking bench for pcs_descrambler_ctrl: bit-serial reference model plus directed vectors.
// Counter checks are compiled in when PCS_DESCR_SH_ERR_CNT_EN is defined.
module tb_pcs_descrambler_ctrl;

    logic        CLK = 1'b0;
    logic        rst;
    logic        lock_in;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_hdr;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_hdr;
    logic [63:0] out_data;
    logic        primed;
`ifdef PCS_DESCR_SH_ERR_CNT_EN
    logic [1:0]  sh_err_cnt;
    logic        sh_err_clr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pcs_descrambler_ctrl #(
        .DATA_WIDTH(64),
        .HDR_WIDTH (2),
`ifdef PCS_DESCR_SH_ERR_CNT_EN
        .CNT_WIDTH (2)
`else
        .CNT_WIDTH (16)
`endif
    ) dut (
        .CLK      (CLK),
        .rst      (rst),
        .lock_in  (lock_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_hdr   (in_hdr),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_hdr  (out_hdr),
        .out_data (out_data),
        .primed   (primed)
`ifdef PCS_DESCR_SH_ERR_CNT_EN
        ,
        .sh_err_cnt(sh_err_cnt),
        .sh_err_clr(sh_err_clr)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: transaction queue + bit-serial descrambler
    typedef struct packed {
        logic [1:0]  hdr;
        logic [63:0] data;
    } blk_t;

    blk_t        m_q[$];
    int          m_state = 0;        // 0 unlocked, 1 waiting for priming block, 2 running
    logic [57:0] m_sr = '0;          // m_sr[0] is the most recent received line bit
    logic        m_ready;
    logic [63:0] m_out;
    logic        m_x;

    always @(posedge CLK or posedge rst) begin
        if (rst) begin
            m_state = 0;
            m_sr    = '0;
            m_q.delete();
        end else begin
            m_ready = lock_in && (m_state != 0) && (m_q.size() == 0 || out_ready);
            if (m_q.size() != 0 && out_ready) m_q.pop_front();
            if (!lock_in) begin
                m_q.delete();
                m_state = 0;
            end else if (in_valid && m_ready) begin
                for (int b = 0; b < 64; b++) begin
                    m_x      = in_data[b];
                    m_out[b] = m_x ^ m_sr[38] ^ m_sr[57];
                    m_sr     = {m_sr[56:0], m_x};
                end
                if (m_state == 2) m_q.push_back('{hdr: in_hdr, data: m_out});
                m_state = 2;
            end else if (m_state == 0) begin
                m_state = 1;
            end
        end
    end

    // ---------------- plaintext scoreboard fed by the bench scrambler
    logic [63:0] plain_q[$];
    logic [57:0] sc_sr;

    always @(negedge CLK) begin
        if (!rst) begin
            check("in_ready", {63'd0, in_ready},
                  {63'd0, lock_in && m_state != 0 && (m_q.size() == 0 || out_ready)});
            check("out_valid", {63'd0, out_valid}, {63'd0, m_q.size() != 0});
            check("primed", {63'd0, primed}, {63'd0, m_state == 2});
            if (m_q.size() != 0) begin
                check("out_hdr", {62'd0, out_hdr}, {62'd0, m_q[0].hdr});
                check("out_data", out_data, m_q[0].data);
            end
            if (out_valid && out_ready && plain_q.size() != 0) begin
                check("plaintext", out_data, plain_q.pop_front());
            end
        end
    end

    // ---------------- drivers (called at posedge + 1)
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [1:0] h, input logic [63:0] d);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_hdr   = h;
        in_data  = d;
        for (int n = 0; n < 50; n++) begin
            @(negedge CLK);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed low for block %h", d);
        end
    endtask

    function automatic logic [63:0] scramble(input logic [63:0] p);
        logic [63:0] s;
        for (int b = 0; b < 64; b++) begin
            s[b]  = p[b] ^ sc_sr[38] ^ sc_sr[57];
            sc_sr = {sc_sr[56:0], s[b]};
        end
        return s;
    endfunction

    task automatic send_plain(input logic [1:0] h, input logic [63:0] p, input bit verify);
        logic [63:0] s;
        s = scramble(p);
        if (verify) plain_q.push_back(p);
        send(h, s);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] pa;
        rst       = 1'b1;
        lock_in   = 1'b0;
        in_valid  = 1'b0;
        in_hdr    = 2'b00;
        in_data   = '0;
        out_ready = 1'b1;
        sc_sr     = '0;
`ifdef PCS_DESCR_SH_ERR_CNT_EN
        sh_err_clr = 1'b0;
`endif

        // Reset state
        step();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_hdr", {62'd0, out_hdr}, 64'd0);
        check("rst_primed", {63'd0, primed}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        step();

        // Directed: prime with zero, then single-bit block
        lock_in = 1'b1;
        step();
        check("idle_not_primed", {63'd0, primed}, 64'd0);
        send(2'b01, 64'h0);
        @(negedge CLK);
        check("prime_no_output", {63'd0, out_valid}, 64'd0);
        check("prime_done", {63'd0, primed}, 64'd1);
        step();
        send(2'b01, 64'h1);
        @(negedge CLK);
        check("bit0_valid", {63'd0, out_valid}, 64'd1);
        check("bit0_data", out_data, 64'h0400_0080_0000_0001);
        step();
        send(2'b10, 64'h0);
        @(negedge CLK);
        check("zero_data", out_data, 64'h0);
        check("zero_hdr", {62'd0, out_hdr}, 64'd2);
        step();

        // Random scrambled stream from a random seed
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
        sc_sr = {$urandom, $urandom};
        send_plain(2'b01, {$urandom, $urandom}, 1'b0);
        for (int k = 1; k < 100; k++) begin
            send_plain(2'($urandom_range(0, 3)), {$urandom, $urandom}, 1'b1);
        end
        step();
        step();
        check("stream_drained", 64'(plain_q.size()), 64'd0);

        // Backpressure: hold out_ready low for 5 cycles
        pa = {$urandom, $urandom};
        send_plain(2'b01, pa, 1'b1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_hdr    = 2'b10;
        in_data   = 64'hDEAD_BEEF_0000_0000;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_hold", out_data, pa);
        end
        step();
        out_ready = 1'b1;
        send_plain(2'b10, {$urandom, $urandom}, 1'b1);
        send_plain(2'b01, {$urandom, $urandom}, 1'b1);
        step();
        step();
        check("stall_drained", 64'(plain_q.size()), 64'd0);

        // Lock loss with a pending block and a block offered in the same cycle
        send_plain(2'b01, {$urandom, $urandom}, 1'b1);
        out_ready = 1'b0;
        lock_in   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h1234_5678_9ABC_DEF0;
        @(negedge CLK);
        check("unlock_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        @(negedge CLK);
        check("unlock_valid", {63'd0, out_valid}, 64'd0);
        check("unlock_primed", {63'd0, primed}, 64'd0);
        plain_q.delete();
        step();
        in_valid  = 1'b0;
        lock_in   = 1'b1;
        out_ready = 1'b1;
        step();
        send_plain(2'b01, {$urandom, $urandom}, 1'b0);
        for (int k = 0; k < 5; k++) begin
            send_plain(2'b10, {$urandom, $urandom}, 1'b1);
        end
        step();
        step();
        check("relock_drained", 64'(plain_q.size()), 64'd0);

        // Asynchronous reset with a pending block
        send_plain(2'b10, {$urandom, $urandom}, 1'b1);
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {63'd0, out_valid}, 64'd0);
        check("arst_data", out_data, 64'd0);
        check("arst_hdr", {62'd0, out_hdr}, 64'd0);
        check("arst_primed", {63'd0, primed}, 64'd0);
        check("arst_in_ready", {63'd0, in_ready}, 64'd0);
        plain_q.delete();
        @(posedge CLK);
        #2;
        rst       = 1'b0;
        out_ready = 1'b1;
        step();

`ifdef PCS_DESCR_SH_ERR_CNT_EN
        // Invalid-header counter: count, saturate, clear-wins
        send(2'b01, 64'h0);
        send(2'b00, 64'h1);
        send(2'b11, 64'h2);
        send(2'b01, 64'h3);
        send(2'b10, 64'h4);
        check("sh_cnt_two", {62'd0, sh_err_cnt}, 64'd2);
        send(2'b00, 64'h5);
        check("sh_cnt_three", {62'd0, sh_err_cnt}, 64'd3);
        send(2'b11, 64'h6);
        check("sh_cnt_sat", {62'd0, sh_err_cnt}, 64'd3);
        sh_err_clr = 1'b1;
        send(2'b00, 64'h7);
        sh_err_clr = 1'b0;
        check("sh_cnt_clr", {62'd0, sh_err_cnt}, 64'd0);
        step();
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
